// File: rtl/binary_to_bcd_stream.sv
// Handshaked binary-to-BCD converter: sequential shift-add-3, one source bit per cycle.
// Optional leading-zero blanking mask is built when BIN2BCD_BLANK_EN is defined.
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// SHIFT | shift-add-3 in progress, busy=1
// DONE  | result presented, held until out_ready
module binary_to_bcd_stream #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter bit SIGNED = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic [DIGITS-1:0]     out_blank,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Decimal digits needed for the largest unsigned WIDTH-bit value.
  function automatic int min_digits(input int w);
    longint unsigned v;
    int d;
    v = (64'd1 << w) - 64'd1;
    d = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 0) begin
        d++;
        v = v / 10;
      end
    end
    return d;
  endfunction

  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("binary_to_bcd_stream: WIDTH must be in 2..32");
  end
  if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
    $error("binary_to_bcd_stream: DIGITS too small for WIDTH");
  end

  logic [1:0]             state_q, state_d;
  logic [WIDTH-1:0]       src_q, src_d;
  logic [BCD_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic                   neg_q, neg_d;

  logic                   accept;
  logic                   in_neg;
  logic [WIDTH-1:0]       magnitude;
  logic [BCD_W-1:0]       acc_adj;
  logic [BCD_W+WIDTH-1:0] shift_pair;
  logic [BCD_W-1:0]       acc_next;
  logic [WIDTH-1:0]       src_next;

  // Negating the most-negative value wraps to 2^(WIDTH-1), which is its correct magnitude.
  assign in_neg    = SIGNED && in_data[WIDTH-1];
  assign magnitude = in_neg ? (~in_data + WIDTH'(1)) : in_data;

  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == S_SHIFT);
  assign out_valid = (state_q == S_DONE);
  assign out_bcd   = bcd_q;
  assign out_neg   = neg_q;

  always_comb begin
    acc_adj = acc_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) begin
        acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
    end
  end

  assign shift_pair = {acc_adj, src_q} << 1;
  assign acc_next   = shift_pair[BCD_W+WIDTH-1:WIDTH];
  assign src_next   = shift_pair[WIDTH-1:0];

`ifdef BIN2BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_next;
  logic              upper_zero;

  // Digit 0 is never blanked so a zero result still shows "0".
  always_comb begin
    blank_next = '0;
    upper_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      upper_zero    = upper_zero && (acc_next[4*k +: 4] == 4'd0);
      blank_next[k] = upper_zero;
    end
  end

  assign out_blank = blank_q;
`else
  assign out_blank = '0;
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    acc_d   = acc_q;
    count_d = count_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
`ifdef BIN2BCD_BLANK_EN
    blank_d = blank_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
        if (accept) begin
          src_d   = magnitude;
          neg_d   = in_neg;
          acc_d   = '0;
          count_d = CNT_INIT;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        src_d   = src_next;
        acc_d   = acc_next;
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          bcd_d   = acc_next;
`ifdef BIN2BCD_BLANK_EN
          blank_d = blank_next;
`endif
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
      blank_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
`ifdef BIN2BCD_BLANK_EN
      blank_q <= blank_d;
`endif
    end
  end

endmodule

// File: tb/tb_binary_to_bcd_stream.sv
// Directed bench: 16-bit unsigned and 8-bit signed instances, vector tables plus
// back-to-back, backpressure and mid-conversion reset sequences.
module tb_binary_to_bcd_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Instance A: WIDTH=16, DIGITS=5, unsigned
  logic        a_reset, a_in_valid, a_in_ready, a_out_neg, a_out_valid, a_out_ready, a_busy;
  logic [15:0] a_in_data;
  logic [19:0] a_out_bcd;
  logic [4:0]  a_out_blank;

  // Instance B: WIDTH=8, DIGITS=3, signed
  logic        b_reset, b_in_valid, b_in_ready, b_out_neg, b_out_valid, b_out_ready, b_busy;
  logic [7:0]  b_in_data;
  logic [11:0] b_out_bcd;
  logic [2:0]  b_out_blank;

  binary_to_bcd_stream #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b0)) dut_a (
    .clk(clk), .reset(a_reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_bcd(a_out_bcd), .out_neg(a_out_neg),
    .out_blank(a_out_blank), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .busy(a_busy)
  );

  binary_to_bcd_stream #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) dut_b (
    .clk(clk), .reset(b_reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_bcd(b_out_bcd), .out_neg(b_out_neg),
    .out_blank(b_out_blank), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .busy(b_busy)
  );

  typedef struct {
    logic [15:0] din;
    logic [19:0] bcd;
    logic [4:0]  blank;
  } vec16_t;

  typedef struct {
    logic [7:0]  din;
    logic [11:0] bcd;
    logic        neg;
    logic [2:0]  blank;
  } vec8_t;

  vec16_t v16[8];
  vec8_t  v8[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] blank16(input logic [4:0] b);
`ifdef BIN2BCD_BLANK_EN
    return b;
`else
    return 5'b0;
`endif
  endfunction

  function automatic logic [2:0] blank8(input logic [2:0] b);
`ifdef BIN2BCD_BLANK_EN
    return b;
`else
    return 3'b0;
`endif
  endfunction

  task automatic wait_a_valid(output int cyc);
    cyc = 0;
    while (!a_out_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic wait_b_valid(output int cyc);
    cyc = 0;
    while (!b_out_valid && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run16(input string tag, input logic [15:0] din,
                       input logic [19:0] ebcd, input logic [4:0] eblank);
    int cyc;
    @(negedge clk);
    a_in_data = din; a_in_valid = 1'b1; a_out_ready = 1'b0;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_data  = ~din;
    chk({tag, " busy"}, a_busy, 1'b1);
    wait_a_valid(cyc);
    chk({tag, " latency"}, cyc, 16);
    chk({tag, " bcd"}, a_out_bcd, ebcd);
    chk({tag, " neg"}, a_out_neg, 1'b0);
    chk({tag, " blank"}, a_out_blank, blank16(eblank));
    @(negedge clk);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    chk({tag, " idle"}, {a_out_valid, a_in_ready}, 2'b01);
  endtask

  task automatic run8(input string tag, input logic [7:0] din, input logic [11:0] ebcd,
                      input logic eneg, input logic [2:0] eblank);
    int cyc;
    @(negedge clk);
    b_in_data = din; b_in_valid = 1'b1; b_out_ready = 1'b0;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_in_data  = ~din;
    wait_b_valid(cyc);
    chk({tag, " latency"}, cyc, 8);
    chk({tag, " bcd"}, b_out_bcd, ebcd);
    chk({tag, " neg"}, b_out_neg, eneg);
    chk({tag, " blank"}, b_out_blank, blank8(eblank));
    @(negedge clk);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    v16[0] = '{16'hFFFF, 20'h65535, 5'b00000};
    v16[1] = '{16'd0,    20'h00000, 5'b11110};
    v16[2] = '{16'd1234, 20'h01234, 5'b10000};
    v16[3] = '{16'd9,    20'h00009, 5'b11110};
    v16[4] = '{16'd100,  20'h00100, 5'b11000};
    v16[5] = '{16'd10000,20'h10000, 5'b00000};
    v16[6] = '{16'd999,  20'h00999, 5'b11000};
    v16[7] = '{16'd50,   20'h00050, 5'b11100};

    v8[0] = '{8'h80, 12'h128, 1'b1, 3'b000};
    v8[1] = '{8'hFF, 12'h001, 1'b1, 3'b110};
    v8[2] = '{8'h7F, 12'h127, 1'b0, 3'b000};
    v8[3] = '{8'h00, 12'h000, 1'b0, 3'b110};
    v8[4] = '{8'hF6, 12'h010, 1'b1, 3'b100};
    v8[5] = '{8'h64, 12'h100, 1'b0, 3'b000};

    a_reset = 1'b1; a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_reset = 1'b1; b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a_reset = 1'b0; b_reset = 1'b0;

    chk("a reset out_valid", a_out_valid, 1'b0);
    chk("a reset busy", a_busy, 1'b0);
    chk("a reset in_ready", a_in_ready, 1'b1);
    chk("a reset bcd", a_out_bcd, 20'h0);
    chk("a reset neg/blank", {a_out_neg, a_out_blank}, 6'b0);
    chk("b reset state", {b_out_valid, b_busy, b_in_ready, b_out_neg}, 4'b0010);
    chk("b reset bcd", b_out_bcd, 12'h0);

    for (int i = 0; i < 8; i++)
      run16($sformatf("v16[%0d]", i), v16[i].din, v16[i].bcd, v16[i].blank);
    for (int i = 0; i < 6; i++)
      run8($sformatf("v8[%0d]", i), v8[i].din, v8[i].bcd, v8[i].neg, v8[i].blank);

    // Back-to-back: 1234 then 9 with in_valid and out_ready held high.
    @(negedge clk);
    a_in_data = 16'd1234; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_data = 16'd9;
    wait_a_valid(cyc);
    chk("b2b first latency", cyc, 16);
    chk("b2b first bcd", a_out_bcd, 20'h01234);
    chk("b2b in_ready while done", a_in_ready, 1'b1);
    @(posedge clk); #1;
    a_in_data = 16'd7;
    chk("b2b consumed and accepted", {a_out_valid, a_busy}, 2'b01);
    wait_a_valid(cyc);
    chk("b2b second latency", cyc, 16);
    chk("b2b second bcd", a_out_bcd, 20'h00009);
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b back to idle", {a_out_valid, a_in_ready, a_busy}, 3'b010);
    a_out_ready = 1'b0;

    // Backpressure: result must hold for 10 cycles while in_valid is pending.
    @(negedge clk);
    a_in_data = 16'd4321; a_in_valid = 1'b1; a_out_ready = 1'b0;
    @(posedge clk); #1;
    a_in_data = 16'd7777;
    wait_a_valid(cyc);
    chk("bp latency", cyc, 16);
    chk("bp bcd", a_out_bcd, 20'h04321);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp hold %0d", i),
          {a_out_valid, a_in_ready, a_out_neg, a_out_bcd}, {3'b100, 20'h04321});
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release idle", {a_out_valid, a_in_ready, a_busy}, 3'b010);
    a_out_ready = 1'b0;

    // Reset at the 5th SHIFT edge discards the word and clears the held result.
    @(negedge clk);
    a_in_data = 16'd500; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst still shifting", a_busy, 1'b1);
    a_reset = 1'b1;
    @(posedge clk); #1;
    a_reset = 1'b0;
    chk("rst mid state", {a_busy, a_out_valid, a_in_ready}, 3'b001);
    chk("rst mid bcd", a_out_bcd, 20'h0);
    repeat (20) @(posedge clk);
    #1;
    chk("rst no late result", {a_out_valid, a_busy}, 2'b00);
    run16("after rst", 16'd42, 20'h00042, 5'b11100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
